seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_hex_decode.sv | 16 +
 rtl/seg_scan_driver.sv | 118 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: digit count, segment bit
// positions and the hex-to-segment code table (bit order gfedcba).
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Entry n is the segment code for hex digit n (element 0 at the LSB end).
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high 7-segment decode.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg_c
);

    logic [SEG_W-1:0] code_c;

    // Table lookup, then route each code bit to its named segment position.
    assign code_c = SEG_TABLE[nibble];
    assign seg_c  = {code_c[SEG_G], code_c[SEG_F], code_c[SEG_E], code_c[SEG_D],
                     code_c[SEG_C], code_c[SEG_B], code_c[SEG_A]};

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit hex display driver with a one-clock anti-ghosting
// gap per digit slot, frame-synchronous value updates and leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  blank_lz,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_done
);

    localparam int unsigned PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]     prescaler;
    logic [IDX_W-1:0]    index;
    logic [VALUE_W-1:0]  shadow;
    logic [VALUE_W-1:0]  display;
    logic                pending;

    logic                tick_c;
    logic                wrap_c;
    logic                blank_c;
    logic [NIBBLE_W-1:0] nibble_c;
    logic [SEG_W-1:0]    dec_seg_c;

    assign tick_c = (prescaler == PS_W'(PRESCALE - 1));
    assign wrap_c = tick_c && (index == IDX_W'(NUM_DIGITS - 1));

    // Select the display nibble for the digit currently being scanned.
    always_comb begin
        nibble_c = display[3:0];
        case (index)
            2'd0:    nibble_c = display[3:0];
            2'd1:    nibble_c = display[7:4];
            2'd2:    nibble_c = display[11:8];
            2'd3:    nibble_c = display[15:12];
            default: nibble_c = display[3:0];
        endcase
    end

    // Digit i>0 is dark when it and every more significant nibble are zero.
    always_comb begin
        blank_c = 1'b0;
        if (blank_lz) begin
            case (index)
                2'd1:    blank_c = (display[15:4]  == 12'd0);
                2'd2:    blank_c = (display[15:8]  == 8'd0);
                2'd3:    blank_c = (display[15:12] == 4'd0);
                default: blank_c = 1'b0;
            endcase
        end
    end

    seg_hex_decode u_decode (
        .nibble (nibble_c),
        .seg_c  (dec_seg_c)
    );

    // Slot prescaler and digit index.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler <= '0;
            index     <= '0;
        end else begin
            prescaler <= tick_c ? '0 : prescaler + PS_W'(1);
            if (tick_c) begin
                index <= index + IDX_W'(1);
            end
        end
    end

    // Shadow capture and frame-boundary commit; a load on the wrap tick goes straight to display.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end
            if (wrap_c) begin
                if (load) begin
                    display <= value;
                end else if (pending) begin
                    display <= shadow;
                end
                pending <= 1'b0;
            end
        end
    end

    // Registered drive: dark on the cycle after each tick, otherwise the decoded digit.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg        <= '0;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap_c;
            if (tick_c || blank_c) begin
                seg    <= '0;
                dig_en <= '0;
            end else begin
                seg    <= dec_seg_c;
                dig_en <= NUM_DIGITS'(1) << index;
            end
        end
    end

endmodule
